// File: rtl/data_gen_pkg.sv
// rtl/data_gen_pkg.sv - shared constants and state encoding for the demo data counter controller
// Purpose : mode encoding published on the mode output, FSM state type,
//           and default values for the controller parameters.
// Ports   : none (package).
package data_gen_pkg;

   localparam logic [1:0] MODE_MANUAL = 2'b00;
   localparam logic [1:0] MODE_AUTO   = 2'b01;
   localparam logic [1:0] MODE_PAUSE  = 2'b10;

   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_AUTO_PERIOD     = 8;
   localparam int DEF_DATA_W          = 4;
   localparam int DEF_MAX_VAL         = 15;

   // State codes equal the published mode codes so mode is the state register.
   typedef enum logic [1:0] {
      ST_MANUAL  = MODE_MANUAL,
      ST_AUTO    = MODE_AUTO,
      ST_PAUSE   = MODE_PAUSE,
      ST_ILLEGAL = 2'b11
   } state_e;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchroniser, debouncer and press-event generator for one push-button
// Purpose : turns a raw asynchronous button into a one-cycle registered
//           press event on each accepted rising edge of its debounced level.
// Ports   : clk_i   - clock, rising edge
//           rstn_i  - synchronous active-low reset
//           key_i   - raw button, 1 = pressed
//           press_o - one-cycle pulse per accepted press (releases give nothing)
module key_debounce
   import data_gen_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic key_i,
   output logic press_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             level_q;
   logic             level_d;
   logic             level_prev_q;
   logic             press_q;

   // The count tracks how long the synced input has disagreed with the
   // accepted level; the final disagreeing sample flips the level instead
   // of incrementing, so the flip lands on the edge the count would reach
   // DEBOUNCE_CYCLES.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d   = '0;
         level_d = ~level_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         cnt_q        <= '0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
         press_q      <= 1'b0;
      end else begin
         sync1_q      <= key_i;
         sync2_q      <= sync1_q;
         cnt_q        <= cnt_d;
         level_q      <= level_d;
         level_prev_q <= level_q;
         // Edge detect on the registered level, so the event trails the
         // level change by one cycle.
         press_q      <= level_q & ~level_prev_q;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/data_gen_ctrl.sv
// rtl/data_gen_ctrl.sv - MANUAL/AUTO/PAUSE sequencer for the demo data counter
// Purpose : debounces two buttons, runs the mode FSM and period counter,
//           and owns the wrapping data counter with its step strobe.
// Ports   : sysClk - clock, rising edge
//           sysRst - synchronous active-low reset
//           key    - raw buttons; key[0] = mode, key[1] = step/pause
//           data   - current counter value
//           step   - one-cycle strobe when data shows a new value
//           mode   - 00 MANUAL, 01 AUTO, 10 PAUSE
module data_gen_ctrl
   import data_gen_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int AUTO_PERIOD     = DEF_AUTO_PERIOD,
   parameter int DATA_W          = DEF_DATA_W,
   parameter int MAX_VAL         = DEF_MAX_VAL
) (
   input  logic              sysClk,
   input  logic              sysRst,
   input  logic [1:0]        key,
   output logic [DATA_W-1:0] data,
   output logic              step,
   output logic [1:0]        mode
);

   localparam int PER_W = $clog2(AUTO_PERIOD);
   localparam logic [PER_W-1:0]  PER_LAST = PER_W'(AUTO_PERIOD - 1);
   localparam logic [DATA_W-1:0] DATA_MAX = DATA_W'(MAX_VAL);

   logic              press_mode;
   logic              press_step;
   state_e            state_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_d;
   logic              step_q;
   logic [PER_W-1:0]  per_q;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
      .clk_i   (sysClk),
      .rstn_i  (sysRst),
      .key_i   (key[0]),
      .press_o (press_mode)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_step (
      .clk_i   (sysClk),
      .rstn_i  (sysRst),
      .key_i   (key[1]),
      .press_o (press_step)
   );

   // Incremented value with wrap; only ever loaded once per cycle.
   always_comb begin
      data_d = (data_q == DATA_MAX) ? '0 : data_q + 1'b1;
   end

   always_ff @(posedge sysClk) begin
      if (!sysRst) begin
         state_q <= ST_MANUAL;
         data_q  <= '0;
         step_q  <= 1'b0;
         per_q   <= '0;
      end else begin
         step_q <= 1'b0;
         if (press_mode && press_step) begin
            // Both buttons together act as a soft clear from any state.
            state_q <= ST_MANUAL;
            data_q  <= '0;
            per_q   <= '0;
         end else begin
            case (state_q)
               ST_MANUAL: begin
                  if (press_step) begin
                     data_q <= data_d;
                     step_q <= 1'b1;
                  end else if (press_mode) begin
                     state_q <= ST_AUTO;
                     per_q   <= '0;
                  end
               end
               ST_AUTO: begin
                  // Period expiry is independent of button events, so a
                  // pause request on the expiry cycle still gets its step.
                  if (per_q == PER_LAST) begin
                     per_q  <= '0;
                     data_q <= data_d;
                     step_q <= 1'b1;
                  end else begin
                     per_q <= per_q + 1'b1;
                  end
                  if (press_step) begin
                     state_q <= ST_PAUSE;
                  end else if (press_mode) begin
                     state_q <= ST_MANUAL;
                  end
               end
               ST_PAUSE: begin
                  // per_q holds so AUTO resumes mid-period.
                  if (press_step) begin
                     state_q <= ST_AUTO;
                  end else if (press_mode) begin
                     state_q <= ST_MANUAL;
                  end
               end
               default: begin
                  state_q <= ST_MANUAL;
                  per_q   <= '0;
               end
            endcase
         end
      end
   end

   assign data = data_q;
   assign step = step_q;
   assign mode = state_q;

endmodule

// File: tb/tb_data_gen_ctrl.sv
// tb/tb_data_gen_ctrl.sv - self-checking bench for data_gen_ctrl against a behavioural model
module tb_data_gen_ctrl;

   localparam int D   = 4;
   localparam int P   = 5;
   localparam int DW  = 4;
   localparam int MAX = 15;

   logic          sysClk = 1'b0;
   logic          sysRst;
   logic [1:0]    key;
   logic [DW-1:0] data;
   logic          step;
   logic [1:0]    mode;

   data_gen_ctrl #(
      .DEBOUNCE_CYCLES (D),
      .AUTO_PERIOD     (P),
      .DATA_W          (DW),
      .MAX_VAL         (MAX)
   ) dut (
      .sysClk (sysClk),
      .sysRst (sysRst),
      .key    (key),
      .data   (data),
      .step   (step),
      .mode   (mode)
   );

   always #5 sysClk = ~sysClk;

   int errors = 0;
   int checks = 0;

   // Reference model state: raw-key history per button (bit i = sample i
   // edges ago), accepted levels, rise history, and the counter/mode view.
   bit [D+1:0] hist [2];
   bit         lvl  [2];
   bit         rise1 [2];
   bit         rise2 [2];
   int         m_mode;
   int         m_data;
   int         m_per;
   bit         m_step;

   int step_cnt;
   int first_step;
   int phase_edge;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j < 2; j++) begin
         hist[j]  = '0;
         lvl[j]   = 1'b0;
         rise1[j] = 1'b0;
         rise2[j] = 1'b0;
      end
      m_mode = 0;
      m_data = 0;
      m_per  = 0;
      m_step = 1'b0;
   endtask

   task automatic model_step();
      m_data = (m_data + 1) % (MAX + 1);
      m_step = 1'b1;
   endtask

   // One rising edge of the reference model.
   task automatic model_edge(input logic [1:0] k, input logic r);
      bit ev [2];
      bit stable;
      if (!r) begin
         model_reset();
         return;
      end
      for (int j = 0; j < 2; j++) begin
         // A level rise is acted on by the FSM two edges later.
         ev[j]    = rise2[j];
         rise2[j] = rise1[j];
         rise1[j] = 1'b0;
         hist[j]  = {hist[j][D:0], k[j]};
         // After two sync flops the debouncer sees samples from 2 or more
         // edges ago; D consecutive disagreeing samples flip the level.
         stable = 1'b1;
         for (int i = 2; i <= D + 1; i++)
            if (hist[j][i] == lvl[j]) stable = 1'b0;
         if (stable) begin
            lvl[j]   = !lvl[j];
            rise1[j] = lvl[j];
         end
      end
      m_step = 1'b0;
      if (ev[0] && ev[1]) begin
         m_mode = 0;
         m_data = 0;
         m_per  = 0;
      end else if (m_mode == 0) begin
         if (ev[1]) model_step();
         else if (ev[0]) begin
            m_mode = 1;
            m_per  = 0;
         end
      end else if (m_mode == 1) begin
         m_per = (m_per + 1) % P;
         if (m_per == 0) model_step();
         if (ev[1]) m_mode = 2;
         else if (ev[0]) m_mode = 0;
      end else begin
         if (ev[1]) m_mode = 1;
         else if (ev[0]) m_mode = 0;
      end
   endtask

   task automatic cycle(input logic [1:0] k, input logic r);
      key    = k;
      sysRst = r;
      @(posedge sysClk);
      model_edge(k, r);
      @(negedge sysClk);
      chk("data", data, m_data);
      chk("step", step, m_step);
      chk("mode", mode, m_mode);
      if (step === 1'b1) begin
         if (first_step < 0) first_step = phase_edge;
         step_cnt++;
      end
      phase_edge++;
   endtask

   task automatic hold(input logic [1:0] k, input int n);
      repeat (n) cycle(k, 1'b1);
   endtask

   task automatic new_phase();
      step_cnt   = 0;
      first_step = -1;
      phase_edge = 0;
   endtask

   initial begin
      int waited;
      model_reset();
      new_phase();

      // Reset state
      cycle(2'b00, 1'b0);
      cycle(2'b00, 1'b0);
      chk("rst_data", data, 0);
      chk("rst_step", step, 0);
      chk("rst_mode", mode, 0);

      // 1: single clean press in MANUAL
      new_phase();
      hold(2'b10, 10);
      hold(2'b00, 10);
      chk("t1_first_step_edge", first_step, 7);
      chk("t1_step_count", step_cnt, 1);
      chk("t1_data", data, 1);

      // 2: bounce shorter than the debounce window
      cycle(2'b00, 1'b0);
      new_phase();
      repeat (3) begin
         hold(2'b10, 2);
         hold(2'b00, 2);
      end
      hold(2'b00, 8);
      chk("t2_step_count", step_cnt, 0);
      chk("t2_data", data, 0);
      chk("t2_mode", mode, 0);

      // 3: sixteen presses, including the wrap
      cycle(2'b00, 1'b0);
      new_phase();
      for (int i = 0; i < 16; i++) begin
         hold(2'b10, 8);
         hold(2'b00, 8);
         chk("t3_data", data, (i + 1) % 16);
      end
      chk("t3_step_count", step_cnt, 16);

      // 4: AUTO, PAUSE, resume
      cycle(2'b00, 1'b0);
      hold(2'b01, 8);
      hold(2'b00, 8);
      chk("t4_auto", mode, 1);
      hold(2'b00, 6);
      hold(2'b10, 8);
      hold(2'b00, 8);
      chk("t4_pause", mode, 2);
      new_phase();
      hold(2'b00, 20);
      chk("t4_pause_steps", step_cnt, 0);
      hold(2'b10, 8);
      hold(2'b00, 4);
      chk("t4_resume", mode, 1);
      hold(2'b00, 10);

      // 5: simultaneous presses in AUTO at data 6
      waited = 0;
      while (m_data != 6 && waited < 200) begin
         cycle(2'b00, 1'b1);
         waited++;
      end
      chk("t5_reach_data6", (waited < 200), 1);
      chk("t5_in_auto", mode, 1);
      hold(2'b11, 8);
      hold(2'b00, 4);
      chk("t5_data", data, 0);
      chk("t5_mode", mode, 0);

      // 6: reset in AUTO with key[1] held through it
      hold(2'b01, 8);
      hold(2'b00, 12);
      chk("t6_auto", mode, 1);
      key = 2'b10;
      hold(2'b10, 3);
      cycle(2'b10, 1'b0);
      chk("t6_rst_data", data, 0);
      chk("t6_rst_mode", mode, 0);
      chk("t6_rst_step", step, 0);
      new_phase();
      hold(2'b10, 10);
      hold(2'b00, 10);
      chk("t6_first_step_edge", first_step, 7);
      chk("t6_step_count", step_cnt, 1);
      chk("t6_data", data, 1);

      // Random key patterns with occasional resets
      for (int s = 0; s < 150; s++) begin
         logic [1:0] k;
         int len;
         k   = 2'($urandom_range(0, 3));
         len = $urandom_range(1, 12);
         for (int c = 0; c < len; c++)
            cycle(k, ($urandom_range(0, 99) != 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/data_gen_ctrl.md
Name: data_gen_ctrl

Overview:
Synchronous controller that sequences the team's 4-bit demo data counter from two raw push-buttons.
- Synchronises and debounces key[1:0] and turns presses into single-cycle events.
- Runs a MANUAL/AUTO/PAUSE state machine that decides when the counter steps.
- Owns the counter register and publishes the value and a step strobe for display logic.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable cycles needed to accept a key level change (>=1)
AUTO_PERIOD, 8, clock cycles between automatic steps in AUTO (>=2)
DATA_W, 4, counter width
MAX_VAL, 15, last counter value before wrap to 0 (MAX_VAL <= 2^DATA_W-1)

Ports:
sysClk  input  1  system clock, all logic on rising edge
sysRst  input  1  synchronous active-low reset
key  input  2  raw asynchronous buttons, 1 = pressed; key[0] = mode, key[1] = step/pause
data  output  DATA_W  current counter value
step  output  1  one-cycle strobe, high in the cycle data shows a newly incremented value
mode  output  2  00 MANUAL, 01 AUTO, 10 PAUSE (11 unused)

Behaviour:
- Reset (sysRst low at a rising edge): on that edge data=0, step=0, mode=MANUAL. Sync flops, debounce counters, debounced levels and the period counter are all cleared to 0.
- Synchroniser: 2 flops per key. Debouncer per key: counter increments while synced != debounced level and clears when they are equal. At the edge where the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Press event: rising edge of the debounced level, one cycle, registered.
- Latency: first edge sampling key high = edge 0. The debounced level rises after edge DEBOUNCE_CYCLES+1. The press event is usable at edge DEBOUNCE_CYCLES+2. The resulting step/data update is visible after edge DEBOUNCE_CYCLES+3.
- Release produces no event. Any bounce shorter than DEBOUNCE_CYCLES produces no event.
- FSM transitions (evaluated on press events):
  - MANUAL: key[1] press -> step. key[0] press -> AUTO, period counter cleared.
  - AUTO: period counter increments each cycle. When it equals AUTO_PERIOD-1, step and clear the counter. key[1] -> PAUSE. key[0] -> MANUAL.
  - PAUSE: period counter and data hold. key[1] -> AUTO, counter resumes from its held value. key[0] -> MANUAL.
- Simultaneous key[0] and key[1] press events in the same cycle, in any state: data=0, mode=MANUAL, period counter=0, no step.
- Step: data <= (data==MAX_VAL) ? 0 : data+1; step=1 for exactly that cycle. The wrap-around step also pulses step.
- In AUTO, a key[1] press arriving in the same cycle as a period expiry: the step still happens, then the FSM enters PAUSE.
- Mode change and step never double-count: at most one increment per cycle.
- Reset mid-operation aborts everything. A key held through reset is seen as a new press, giving one event DEBOUNCE_CYCLES+2 edges after reset release.
- mode=11 is unreachable; if ever decoded, the next edge goes to MANUAL.

Decomposition:
- Package data_gen_pkg: mode encoding constants (MODE_MANUAL=2'b00, MODE_AUTO=2'b01, MODE_PAUSE=2'b10) and default parameter constants.
- Sub-module key_debounce: synchroniser, debouncer and press-event generator for one key, parameterised by DEBOUNCE_CYCLES. Instantiated twice.
- FSM, period counter and data register stay in data_gen_ctrl.

Test Plan:
(bench uses DEBOUNCE_CYCLES=4, AUTO_PERIOD=5, MAX_VAL=15)
1. MANUAL; key[1] clean high for 10 cycles, then low -> exactly one step pulse, visible after edge 7; data 0->1; no event on release.
2. key[1] toggling every 2 cycles for 12 cycles, then low -> step never asserts; data stays 0; mode stays 00.
3. 16 clean key[1] presses, each 8 cycles high and 8 low -> data 1..15 then 0; step pulses 16 times, including on the wrap.
4. key[0] press -> mode 01; data increments every 5 cycles (1,2,3). key[1] press -> mode 10, data frozen 20 cycles. key[1] press -> mode 01; next step arrives after only the remaining period count.
5. In AUTO with data=6, key[0] and key[1] raised on the same edge -> events coincide; data=0, mode=00, no step that cycle.
6. In AUTO, sysRst low for one edge with key[1] held -> data=0, mode=00, step=0 after that edge; one step pulse after edge 7 post-release; data=1.
